// File: rtl/odev1_sweep_ctrl.sv
// Sweeps the 3-input lab gate circuit through all 8 input vectors, captures F/Q
// for each one and compares them against the expected truth tables.
module odev1_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXP_F         = 8'b1111_1110,
  parameter logic [7:0]  EXP_Q         = 8'b1111_1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       f_in,
  input  logic       q_in,
  output logic [2:0] abc_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_mask,
  output logic [7:0] f_vec,
  output logic [7:0] q_vec
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_idx;
  logic [3:0] r_settle_cnt;
  logic       w_settle_last;
  logic       w_mismatch;
  logic [3:0] w_err_next;

  assign w_settle_last = (r_settle_cnt == 4'(SETTLE_CYCLES - 1));
  assign w_mismatch    = (f_in != EXP_F[r_idx]) || (q_in != EXP_Q[r_idx]);
  assign w_err_next    = err_count + 4'(w_mismatch);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: begin
        if (abort)              w_next = S_IDLE;
        else if (w_settle_last) w_next = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (abort)              w_next = S_IDLE;
        else if (r_idx == 3'd7) w_next = S_DONE;
        else                    w_next = S_SETTLE;
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // done is raised on the final SAMPLE edge so it is high exactly during the DONE cycle;
  // pass uses the post-increment error count so the last vector is included.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= '0;
      r_settle_cnt <= '0;
      abc_out      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      fail_mask    <= '0;
      f_vec        <= '0;
      q_vec        <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx        <= '0;
            r_settle_cnt <= '0;
            abc_out      <= '0;
            busy         <= 1'b1;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_mask    <= '0;
            f_vec        <= '0;
            q_vec        <= '0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_settle_cnt <= '0;
            abc_out      <= '0;
            busy         <= 1'b0;
            pass         <= 1'b0;
          end else if (w_settle_last) begin
            r_settle_cnt <= '0;
          end else begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            abc_out <= '0;
            busy    <= 1'b0;
            pass    <= 1'b0;
          end else begin
            f_vec[r_idx] <= f_in;
            q_vec[r_idx] <= q_in;
            if (w_mismatch) begin
              fail_mask[r_idx] <= 1'b1;
              err_count        <= w_err_next;
            end
            if (r_idx == 3'd7) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              pass    <= (w_err_next == 4'd0);
              abc_out <= '0;
            end else begin
              r_idx   <= r_idx + 3'd1;
              abc_out <= r_idx + 3'd1;
            end
          end
        end
        S_DONE: begin
          abc_out <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_odev1_sweep_ctrl.sv
// Scoreboard bench for odev1_sweep_ctrl: stimulus queues expected sweep results,
// per-DUT monitors pop and compare on each done pulse.
module tb_odev1_sweep_ctrl;

  typedef struct {
    logic [7:0] f;
    logic [7:0] q;
    logic [7:0] mask;
    logic [3:0] err;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests  = 0;
  int failed = 0;

  exp_t sb1[$];
  exp_t sb2[$];

  // DUT1: SETTLE_CYCLES=2
  logic       rst, start1, abort1, f1, q1;
  logic [2:0] abc1;
  logic       busy1, done1, pass1;
  logic [3:0] err1;
  logic [7:0] mask1, fv1, qv1;
  int         fmode = 0;

  // DUT2: SETTLE_CYCLES=1
  logic       start2, f2, q2;
  logic [2:0] abc2;
  logic       busy2, done2, pass2;
  logic [3:0] err2;
  logic [7:0] mask2, fv2, qv2;

  // circuit model: golden F=A|B|C, Q=1, with selectable faults on DUT1
  assign f1 = (|abc1) ^ ((fmode == 2) && (abc1 == 3'd5));
  assign q1 = (fmode == 1) ? 1'b0 : 1'b1;
  assign f2 = |abc2;
  assign q2 = 1'b1;

  odev1_sweep_ctrl #(.SETTLE_CYCLES(2), .EXP_F(8'b1111_1110), .EXP_Q(8'b1111_1111)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .f_in(f1), .q_in(q1),
    .abc_out(abc1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_mask(mask1), .f_vec(fv1), .q_vec(qv1)
  );

  odev1_sweep_ctrl #(.SETTLE_CYCLES(1), .EXP_F(8'b1111_1110), .EXP_Q(8'b1111_1111)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .f_in(f2), .q_in(q2),
    .abc_out(abc2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_mask(mask2), .f_vec(fv2), .q_vec(qv2)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor DUT1
  logic prev_busy1 = 1'b0;
  int   st1 = 0, run1 = 0;
  always @(negedge clk) begin
    if (busy1 === 1'b1 && prev_busy1 !== 1'b1) begin
      st1  = cyc;
      run1 = 0;
    end
    if (busy1 === 1'b1) begin
      chk("d1_abc_step", 32'(abc1), 32'(run1 / 3));
      run1++;
    end
    if (done1 === 1'b1) begin
      if (sb1.size() == 0) begin
        chk("d1_unexpected_done", 32'(done1), 32'd0);
      end else begin
        exp_t e;
        e = sb1.pop_front();
        chk("d1_f_vec", 32'(fv1), 32'(e.f));
        chk("d1_q_vec", 32'(qv1), 32'(e.q));
        chk("d1_fail_mask", 32'(mask1), 32'(e.mask));
        chk("d1_err_count", 32'(err1), 32'(e.err));
        chk("d1_pass", 32'(pass1), 32'(e.pass));
        chk("d1_busy_at_done", 32'(busy1), 32'd0);
        chk("d1_abc_at_done", 32'(abc1), 32'd0);
        chk("d1_latency", 32'(cyc - st1), 32'd24);
        chk("d1_busy_len", 32'(run1), 32'd24);
      end
    end
    prev_busy1 = busy1;
  end

  // monitor DUT2
  logic prev_busy2 = 1'b0;
  int   st2 = 0, run2 = 0;
  always @(negedge clk) begin
    if (busy2 === 1'b1 && prev_busy2 !== 1'b1) begin
      st2  = cyc;
      run2 = 0;
    end
    if (busy2 === 1'b1) begin
      chk("d2_abc_step", 32'(abc2), 32'(run2 / 2));
      run2++;
    end
    if (done2 === 1'b1) begin
      if (sb2.size() == 0) begin
        chk("d2_unexpected_done", 32'(done2), 32'd0);
      end else begin
        exp_t e;
        e = sb2.pop_front();
        chk("d2_f_vec", 32'(fv2), 32'(e.f));
        chk("d2_q_vec", 32'(qv2), 32'(e.q));
        chk("d2_fail_mask", 32'(mask2), 32'(e.mask));
        chk("d2_err_count", 32'(err2), 32'(e.err));
        chk("d2_pass", 32'(pass2), 32'(e.pass));
        chk("d2_latency", 32'(cyc - st2), 32'd16);
        chk("d2_busy_len", 32'(run2), 32'd16);
      end
    end
    prev_busy2 = busy2;
  end

  task automatic push1(logic [7:0] f, logic [7:0] q, logic [7:0] m, logic [3:0] e, logic p);
    exp_t x;
    x.f = f; x.q = q; x.mask = m; x.err = e; x.pass = p;
    sb1.push_back(x);
  endtask

  task automatic pulse_start1();
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  task automatic wait_idle1(string name);
    int n = 0;
    while ((busy1 === 1'b1 || done1 === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(n < 200), 32'd1);
    chk({name, "_sb_drained"}, 32'(sb1.size()), 32'd0);
  endtask

  task automatic wait_abc1(logic [2:0] v, string name);
    int n = 0;
    while (abc1 !== v && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_abc_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic chk_all_zero1(string name);
    chk({name, "_abc"}, 32'(abc1), 32'd0);
    chk({name, "_busy"}, 32'(busy1), 32'd0);
    chk({name, "_done"}, 32'(done1), 32'd0);
    chk({name, "_pass"}, 32'(pass1), 32'd0);
    chk({name, "_err"}, 32'(err1), 32'd0);
    chk({name, "_mask"}, 32'(mask1), 32'd0);
    chk({name, "_fvec"}, 32'(fv1), 32'd0);
    chk({name, "_qvec"}, 32'(qv1), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; abort1 = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_all_zero1("reset");
    chk("reset_d2_busy", 32'(busy2), 32'd0);
    chk("reset_d2_done", 32'(done2), 32'd0);

    // golden sweep
    fmode = 0;
    push1(8'hFE, 8'hFF, 8'h00, 4'd0, 1'b1);
    pulse_start1();
    wait_idle1("golden");

    // abort while abc_out==3; vectors 0..2 already captured
    pulse_start1();
    wait_abc1(3'd3, "abort");
    abort1 = 1'b1;
    @(negedge clk) abort1 = 1'b0;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_abc", 32'(abc1), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_pass", 32'(pass1), 32'd0);
    chk("abort_fvec", 32'(fv1), 32'h06);
    chk("abort_qvec", 32'(qv1), 32'h07);
    chk("abort_err", 32'(err1), 32'd0);
    repeat (30) @(negedge clk);
    chk("abort_stays_idle", 32'(busy1), 32'd0);
    push1(8'hFE, 8'hFF, 8'h00, 4'd0, 1'b1);
    pulse_start1();
    wait_idle1("post_abort");

    // Q stuck at 0
    fmode = 1;
    push1(8'hFE, 8'h00, 8'hFF, 4'd8, 1'b0);
    pulse_start1();
    wait_idle1("q_stuck");

    // F inverted at vector 5 only
    fmode = 2;
    push1(8'hDE, 8'hFF, 8'h20, 4'd1, 1'b0);
    pulse_start1();
    wait_idle1("f_inv5");

    // start re-pulsed mid-sweep is ignored
    fmode = 0;
    push1(8'hFE, 8'hFF, 8'h00, 4'd0, 1'b1);
    pulse_start1();
    wait_abc1(3'd2, "restart");
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    wait_idle1("restart");

    // reset mid-sweep clears everything
    pulse_start1();
    wait_abc1(3'd6, "midrst");
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk_all_zero1("midrst");
    repeat (30) @(negedge clk);
    chk("midrst_stays_idle", 32'(busy1), 32'd0);

    // SETTLE_CYCLES=1 golden sweep on DUT2
    begin
      exp_t x;
      int   n;
      x.f = 8'hFE; x.q = 8'hFF; x.mask = 8'h00; x.err = 4'd0; x.pass = 1'b1;
      sb2.push_back(x);
      @(negedge clk) start2 = 1'b1;
      @(negedge clk) start2 = 1'b0;
      n = 0;
      while ((busy2 === 1'b1 || done2 === 1'b1) && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("s1_idle_timeout", 32'(n < 200), 32'd1);
      chk("s1_sb_drained", 32'(sb2.size()), 32'd0);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
